fetch_stage: RTL

- Instruction-fetch front end of the ARM-subset pipeline.
- Owns the program counter and drives the word address into the 64-entry instruction ROM.
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles sequential fetch, branch redirect from Execute, hazard stalls and flushes, and a sticky out-of-range fetch fault.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_pc_register.sv | 38 +++
 rtl/fetch_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_stage_pkg;

    // Fetch-stage control states: normal fetching, or halted on an out-of-range PC.
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // Byte distance between consecutive instruction words.
    localparam logic [31:0] WORD_BYTES     = 32'd4;
    // ARM reads R15 as the fetch address plus two instructions.
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;
    // Value placed in instr_d when decode receives a bubble.
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter: word-aligned flop with enable, branch redirect mux and
// sequential increment. Wraps modulo 2^32.
module fetch_stage_pc_register
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        redirect,
    input  logic [29:0] target_word,
    output logic [31:0] pc
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;

    // Redirect replaces the PC with the word-aligned target; otherwise step one word.
    always_comb begin
        pc_next = pc_reg + WORD_BYTES;
        if (redirect) begin
            pc_next = {target_word, 2'b00};
        end
    end

    // PC flop; the reset value is forced word-aligned so pc[1:0] is always 00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= {RESET_PC[31:2], 2'b00};
        end else if (enable) begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, and captures
// the returned word into the IF/ID register. An out-of-range fetch latches a
// sticky fault that freezes the PC and feeds bubbles to decode until reset.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_taken_e,
    input  logic [31:0] branch_target_e,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus8_d,
    output logic        valid_d,
    output logic        fetch_fault
);

    fetch_state_t state_reg;
    fetch_state_t state_next;

    logic        out_of_range;
    logic        pc_enable;
    logic        pc_redirect;
    logic        ifid_capture;
    logic        ifid_clear;
    logic        target_low_unused;

    logic [31:0] instr_d_reg;
    logic [31:0] pc_plus8_d_reg;
    logic        valid_d_reg;

    // Branch targets are byte addresses; the low two bits are dropped silently.
    assign target_low_unused = ^branch_target_e[1:0];

    // Word index compared at full 32-bit width so very large depths never fault.
    assign out_of_range = ({2'b00, pc_f[31:2]} >= IMEM_DEPTH);

    fetch_stage_pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk         (clk),
        .reset       (reset),
        .enable      (pc_enable),
        .redirect    (pc_redirect),
        .target_word (branch_target_e[31:2]),
        .pc          (pc_f)
    );

    // Next state plus PC and IF/ID controls; branch beats stall_f, flush beats stall_d.
    always_comb begin
        state_next   = state_reg;
        pc_enable    = 1'b0;
        pc_redirect  = 1'b0;
        ifid_capture = 1'b0;
        ifid_clear   = 1'b0;
        if (state_reg == RUN) begin
            if (out_of_range) begin
                // The out-of-range word is never captured and the PC stops here.
                state_next = FAULT;
                ifid_clear = 1'b1;
            end else begin
                pc_redirect = branch_taken_e;
                pc_enable   = branch_taken_e | ~stall_f;
                if (flush_d) begin
                    ifid_clear = 1'b1;
                end else if (!stall_d) begin
                    ifid_capture = 1'b1;
                end
            end
        end else begin
            // Halted: all hazard and branch inputs are ignored.
            ifid_clear = 1'b1;
        end
    end

    // FSM state register; FAULT is left only through reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // IF/ID pipeline register: bubble, hold, or capture the fetched word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d_reg    <= NOP_INSTR;
            pc_plus8_d_reg <= 32'h0000_0000;
            valid_d_reg    <= 1'b0;
        end else if (ifid_clear) begin
            instr_d_reg    <= NOP_INSTR;
            pc_plus8_d_reg <= 32'h0000_0000;
            valid_d_reg    <= 1'b0;
        end else if (ifid_capture) begin
            instr_d_reg    <= instr_f;
            pc_plus8_d_reg <= pc_f + PC_READ_OFFSET;
            valid_d_reg    <= 1'b1;
        end
    end

    assign instr_d     = instr_d_reg;
    assign pc_plus8_d  = pc_plus8_d_reg;
    assign valid_d     = valid_d_reg;
    assign fetch_fault = (state_reg == FAULT);

endmodule
